// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// Optional macro UART_LOOPBACK_EN feeds the receiver from the transmit line for self-test.
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } state_t;

  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_serial_q, tx_serial_d;
  logic            tx_active_q, tx_active_d;
  logic            tx_done_q, tx_done_d;

  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_dv_q, rx_dv_d;
  logic            rx_meta_q, rx_sync_q;
  logic            rx_line;

`ifdef UART_LOOPBACK_EN
  logic unused_rx_serial;
  assign unused_rx_serial = i_RX_Serial;
  assign rx_line = tx_active_q ? tx_serial_q : 1'b1;
`else
  assign rx_line = i_RX_Serial;
`endif

  // Transmit next-state: the line value for each bit is prepared one cycle ahead.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_cnt_d    = CNT_ZERO;
        tx_idx_d    = 3'd0;
        if (i_TX_DV) begin
          tx_byte_d   = i_TX_Byte;
          tx_serial_d = 1'b0;
          tx_active_d = 1'b1;
          tx_state_d  = ST_START;
        end else begin
          tx_state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = CNT_ZERO;
          tx_serial_d = tx_byte_q[0];
          tx_state_d  = ST_DATA;
        end else begin
          tx_cnt_d    = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_idx_q == 3'd7) begin
            tx_serial_d = 1'b1;
            tx_state_d  = ST_STOP;
          end else begin
            tx_idx_d    = tx_idx_q + 3'd1;
            tx_serial_d = tx_byte_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = CNT_ZERO;
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = ST_CLEANUP;
        end else begin
          tx_cnt_d    = tx_cnt_q + CNT_ONE;
        end
      end
      ST_CLEANUP: begin
        tx_state_d = ST_IDLE;
      end
      default: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_cnt_d    = CNT_ZERO;
        tx_state_d  = ST_IDLE;
      end
    endcase
  end

  // Transmit registers; reset drives the line high at once.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= CNT_ZERO;
      tx_idx_q    <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Synchronizer resets to the idle line level so reset release is not seen as a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_line;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive next-state: mid-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        rx_idx_d = 3'd0;
        if (!rx_sync_q) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d = CNT_ZERO;
          if (!rx_sync_q) begin
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d             = CNT_ZERO;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d   = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = ST_CLEANUP;
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end else begin
            rx_byte_d = rx_byte_q;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_CLEANUP: begin
        rx_state_d = ST_IDLE;
      end
      default: begin
        rx_cnt_d   = CNT_ZERO;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // Receive registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_TX_Active = tx_active_q;
  assign o_TX_Serial = tx_serial_q;
  assign o_TX_Done   = tx_done_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomized self-checking bench for uart_transceiver against a frame-timing reference model.
`timescale 1ns/1ps
module tb_uart_transceiver;
  localparam int C = 217;
  localparam int H = (C - 1) / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_mode = 1'b0;
  logic       rx_drive = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit         m_tx_busy;
  int         m_tx_k;
  logic [9:0] m_tx_frame;
  logic       m_meta, m_sync;
  bit         m_rx_busy;
  int         m_rx_s;
  logic [7:0] m_rx_data, m_rx_byte;
  logic       m_rx_dv;
  int         dv_seen = 0;
  logic [7:0] last_rx = 8'h00;

  uart_transceiver #(.CLKS_PER_BIT(C)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte),
    .o_TX_Active(tx_active), .o_TX_Serial(tx_serial), .o_TX_Done(tx_done),
    .i_RX_Serial(rx_serial), .o_RX_DV(rx_dv), .o_RX_Byte(rx_byte)
  );

  always #20 clk = ~clk;

`ifdef UART_LOOPBACK_EN
  assign rx_serial = 1'b0;
`else
  assign rx_serial = rx_mode ? rx_drive : (tx_active ? tx_serial : 1'b1);
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx_busy = 1'b0; m_tx_k = 0; m_tx_frame = 10'h3FF;
    m_meta = 1'b1; m_sync = 1'b1;
    m_rx_busy = 1'b0; m_rx_s = 0; m_rx_data = 8'h00; m_rx_byte = 8'h00; m_rx_dv = 1'b0;
  endtask

  // {serial, active, done} implied by elapsed time since the frame was accepted
  function automatic logic [2:0] exp_tx();
    if (m_tx_busy && m_tx_k < 10 * C) return {m_tx_frame[m_tx_k / C], 1'b1, 1'b0};
    else if (m_tx_busy) return 3'b101;
    else return 3'b100;
  endfunction

  task automatic check_and_step();
    logic [2:0] t;
    logic       line;
    logic       v;
    if (rst === 1'b1) begin
      model_reset();
      chk("reset_outputs", {tx_serial, tx_active, tx_done, rx_dv, rx_byte}, {3'b100, 1'b0, 8'h00});
    end else begin
      t = exp_tx();
      chk("cycle_outputs", {tx_serial, tx_active, tx_done, rx_dv, rx_byte}, {t, m_rx_dv, m_rx_byte});
      if (rx_dv === 1'b1) begin
        dv_seen++;
        last_rx = rx_byte;
      end
      line = t[1] ? t[2] : 1'b1;
`ifndef UART_LOOPBACK_EN
      if (rx_mode) line = rx_drive;
`endif
      if (!m_tx_busy) begin
        if (tx_dv) begin
          m_tx_busy = 1'b1; m_tx_k = 0; m_tx_frame = {1'b1, tx_byte, 1'b0};
        end
      end else if (m_tx_k == 10 * C) m_tx_busy = 1'b0;
      else m_tx_k++;
      v = m_sync; m_sync = m_meta; m_meta = line; m_rx_dv = 1'b0;
      if (!m_rx_busy) begin
        if (v == 1'b0) begin m_rx_busy = 1'b1; m_rx_s = 0; end
      end else begin
        if (m_rx_s == H) begin
          if (v) m_rx_busy = 1'b0;
        end else if (m_rx_s > H && m_rx_s < H + 9 * C && (m_rx_s - H) % C == 0) begin
          m_rx_data[(m_rx_s - H) / C - 1] = v;
        end else if (m_rx_s == H + 9 * C) begin
          if (v) begin m_rx_byte = m_rx_data; m_rx_dv = 1'b1; end
        end else if (m_rx_s == H + 9 * C + 1) begin
          m_rx_busy = 1'b0;
        end
        m_rx_s++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    tx_byte = b; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int budget);
    int start;
    int n;
    start = dv_seen; n = 0;
    while (dv_seen == start && n < budget) begin tick(); n++; end
    chk(name, (dv_seen != start) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_tx_idle(input string name);
    int n;
    n = 0;
    while (tx_active === 1'b1 && n < 12 * C) begin tick(); n++; end
    chk(name, tx_active, 1'b0);
  endtask

  // drives a full frame on the RX pin; a pending tx_dv is consumed on the first cycle
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10 * C; i++) begin
      rx_drive = f[i / C];
      tick();
      tx_dv = 1'b0;
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    int         dv_before;
    logic [7:0] b;
    logic       stp;
    logic [9:0] exp_line;
    int         r;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    ticks(3);
    chk("reset_rx_byte", rx_byte, 8'h00);
    chk("reset_tx_serial", tx_serial, 1'b1);
    rst = 1'b0;

    // 1: loop a byte from TX to RX
    ticks(2);
    dv_before = dv_seen;
    pulse_tx(8'h3F);
    wait_rx("t1_rx_dv", 10 * C + 8);
    chk("t1_rx_byte", last_rx, 8'h3F);
    wait_tx_idle("t1_tx_idle");
    ticks(5);
    chk("t1_dv_once", dv_seen - dv_before, 1);

    // 2: TX waveform of 8'hA5 sampled mid-bit
    exp_line = 10'b1_1010_0101_0;
    pulse_tx(8'hA5);
    for (int i = 0; i < 10; i++) begin
      ticks(i == 0 ? H : C);
      chk($sformatf("t2_bit%0d", i), tx_serial, exp_line[i]);
    end
    ticks(C - H);
    chk("t2_done_pulse", {tx_done, tx_active}, 2'b10);
    tick();
    chk("t2_after_done", {tx_done, tx_active}, 2'b00);
    chk("t2_rx_byte", last_rx, 8'hA5);
    ticks(5);

`ifndef UART_LOOPBACK_EN
    // 3: short low glitch is rejected, then a real byte arrives
    rx_mode = 1'b1; rx_drive = 1'b1;
    ticks(10);
    dv_before = dv_seen;
    rx_drive = 1'b0; ticks(50); rx_drive = 1'b1; ticks(300);
    chk("t3_glitch_no_dv", dv_seen - dv_before, 0);
    send_rx(8'h55, 1'b1);
    ticks(20);
    chk("t3_rx_dv", dv_seen - dv_before, 1);
    chk("t3_rx_byte", last_rx, 8'h55);

    // 4: framing error leaves the held byte untouched
    dv_before = dv_seen;
    send_rx(8'hC3, 1'b0);
    ticks(3 * C);
    chk("t4_no_dv", dv_seen - dv_before, 0);
    chk("t4_byte_held", rx_byte, 8'h55);
    rx_mode = 1'b0;
`endif

    // 5: strobe during a frame is ignored
    dv_before = dv_seen;
    pulse_tx(8'h00);
    ticks(1000);
    pulse_tx(8'hFF);
    wait_tx_idle("t5_first_idle");
    ticks(3 * C);
    chk("t5_one_frame", dv_seen - dv_before, 1);
    chk("t5_byte0", last_rx, 8'h00);
    chk("t5_no_queue", tx_active, 1'b0);
    pulse_tx(8'hFF);
    wait_rx("t5_rx_dv2", 10 * C + 8);
    chk("t5_byte1", last_rx, 8'hFF);
    wait_tx_idle("t5_second_idle");
    ticks(5);

    // 6: reset mid-frame, then recover
    pulse_tx(8'($urandom));
    ticks(500);
    rst = 1'b1;
    #1;
    chk("t6_reset_now", {tx_serial, tx_active, rx_dv}, 3'b100);
    ticks(2);
    rst = 1'b0;
    ticks(3);
    pulse_tx(8'h3F);
    wait_rx("t6_rx_dv", 10 * C + 8);
    chk("t6_rx_byte", last_rx, 8'h3F);
    wait_tx_idle("t6_tx_idle");
    ticks(5);

    // random traffic: looped frames with stray strobes, or direct RX frames alongside TX
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 1);
`ifdef UART_LOOPBACK_EN
      r = 0;
`endif
      b = 8'($urandom);
      if (r == 0) begin
        rx_mode = 1'b0;
        pulse_tx(b);
        ticks($urandom_range(100, 1500));
        pulse_tx(8'($urandom));
        wait_rx($sformatf("rnd%0d_dv", it), 10 * C + 8);
        chk($sformatf("rnd%0d_loop_byte", it), last_rx, b);
        wait_tx_idle($sformatf("rnd%0d_idle", it));
        ticks($urandom_range(1, 20));
      end else begin
        rx_mode = 1'b1;
        stp = ($urandom_range(0, 3) != 0);
        dv_before = dv_seen;
        tx_byte = 8'($urandom); tx_dv = 1'b1;
        send_rx(b, stp);
        ticks(2 * C);
        chk($sformatf("rnd%0d_rx_count", it), dv_seen - dv_before, stp ? 1 : 0);
        if (stp) chk($sformatf("rnd%0d_rx_byte", it), last_rx, b);
        wait_tx_idle($sformatf("rnd%0d_tx_idle", it));
        ticks(5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
